// File: rtl/axi_wr_mux_rr.sv
// ---------------------------------------------------------------------------------------------
// axi_wr_mux_rr
//
// N-master to 1-slave AXI4 write-channel multiplexer with a built-in round-robin arbiter.
// One master owns the slave for a whole write transaction: its AW handshake, every W beat
// and finally the B handshake. Ownership is released only once B has been accepted.
// WLAST toward the slave is regenerated from AWLEN; a master whose own WLAST disagrees
// with the beat count raises a one-cycle wlast_err pulse.
//
// Ports
//   ACLK, ARESET        clock (rising edge) and synchronous active-high reset
//   m_AW*               per-master AW fields, packed; master i occupies slice i
//   m_AWVALID/AWREADY   per-master AW handshake
//   m_W*                per-master W fields, packed
//   m_WVALID/WREADY     per-master W handshake
//   m_BID, m_BRESP      B ID/response broadcast to all masters
//   m_BVALID/BREADY     per-master B handshake
//   s_AW*, s_W*, s_B*   single slave-side write channels
//   grant               one-hot current owner, zero when idle
//   busy                high while a transaction is in flight
//   wlast_err           one-cycle pulse after a W handshake with a wrong master WLAST
// ---------------------------------------------------------------------------------------------
module axi_wr_mux_rr #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned USER_WIDTH  = 1,
    parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned IDX_WIDTH   = $clog2(NUM_MASTERS)
) (
    input  logic                              ACLK,
    input  logic                              ARESET,

    // Master-side AW
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_AWID,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_AWADDR,
    input  logic [NUM_MASTERS*8-1:0]          m_AWLEN,
    input  logic [NUM_MASTERS*3-1:0]          m_AWSIZE,
    input  logic [NUM_MASTERS*2-1:0]          m_AWBURST,
    input  logic [NUM_MASTERS-1:0]            m_AWLOCK,
    input  logic [NUM_MASTERS*4-1:0]          m_AWCACHE,
    input  logic [NUM_MASTERS*3-1:0]          m_AWPROT,
    input  logic [NUM_MASTERS*4-1:0]          m_AWQOS,
    input  logic [NUM_MASTERS*4-1:0]          m_AWREGION,
    input  logic [NUM_MASTERS*USER_WIDTH-1:0] m_AWUSER,
    input  logic [NUM_MASTERS-1:0]            m_AWVALID,
    output logic [NUM_MASTERS-1:0]            m_AWREADY,

    // Master-side W
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_WDATA,
    input  logic [NUM_MASTERS*STRB_WIDTH-1:0] m_WSTRB,
    input  logic [NUM_MASTERS-1:0]            m_WLAST,
    input  logic [NUM_MASTERS*USER_WIDTH-1:0] m_WUSER,
    input  logic [NUM_MASTERS-1:0]            m_WVALID,
    output logic [NUM_MASTERS-1:0]            m_WREADY,

    // Master-side B
    output logic [ID_WIDTH-1:0]               m_BID,
    output logic [1:0]                        m_BRESP,
    output logic [NUM_MASTERS-1:0]            m_BVALID,
    input  logic [NUM_MASTERS-1:0]            m_BREADY,

    // Slave-side AW
    output logic [ID_WIDTH-1:0]               s_AWID,
    output logic [ADDR_WIDTH-1:0]             s_AWADDR,
    output logic [7:0]                        s_AWLEN,
    output logic [2:0]                        s_AWSIZE,
    output logic [1:0]                        s_AWBURST,
    output logic                              s_AWLOCK,
    output logic [3:0]                        s_AWCACHE,
    output logic [2:0]                        s_AWPROT,
    output logic [3:0]                        s_AWQOS,
    output logic [3:0]                        s_AWREGION,
    output logic [USER_WIDTH-1:0]             s_AWUSER,
    output logic                              s_AWVALID,
    input  logic                              s_AWREADY,

    // Slave-side W
    output logic [DATA_WIDTH-1:0]             s_WDATA,
    output logic [STRB_WIDTH-1:0]             s_WSTRB,
    output logic                              s_WLAST,
    output logic [USER_WIDTH-1:0]             s_WUSER,
    output logic                              s_WVALID,
    input  logic                              s_WREADY,

    // Slave-side B
    input  logic [ID_WIDTH-1:0]               s_BID,
    input  logic [1:0]                        s_BRESP,
    input  logic                              s_BVALID,
    output logic                              s_BREADY,

    // Status
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              busy,
    output logic                              wlast_err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StData = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    localparam logic [IDX_WIDTH-1:0]   LastIdx = IDX_WIDTH'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] OneHot0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    logic [1:0]             state_q, state_d;
    logic [IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_WIDTH-1:0]   g_q, g_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [7:0]             beat_cnt_q, beat_cnt_d;
    logic                   wlast_err_q, wlast_err_d;

    logic                   arb_found;
    logic [IDX_WIDTH-1:0]   arb_idx;
    logic                   aw_hs, w_hs, b_hs;
    logic                   last_beat;
    logic                   m_wlast_sel;

    // ------------------------------------------------------------------
    // Round-robin pick: first requester scanning rr_ptr, rr_ptr+1, ...
    // ------------------------------------------------------------------
    always_comb begin
        int unsigned cand;
        cand      = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (!arb_found && m_AWVALID[cand[IDX_WIDTH-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Field mux: AND-OR select on the one-hot grant, so every s_* field
    // is zero whenever no master owns the slave.
    // ------------------------------------------------------------------
    always_comb begin
        s_AWID      = '0;
        s_AWADDR    = '0;
        s_AWLEN     = '0;
        s_AWSIZE    = '0;
        s_AWBURST   = '0;
        s_AWLOCK    = 1'b0;
        s_AWCACHE   = '0;
        s_AWPROT    = '0;
        s_AWQOS     = '0;
        s_AWREGION  = '0;
        s_AWUSER    = '0;
        s_WDATA     = '0;
        s_WSTRB     = '0;
        s_WUSER     = '0;
        m_wlast_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                s_AWID      = m_AWID[i*ID_WIDTH +: ID_WIDTH];
                s_AWADDR    = m_AWADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_AWLEN     = m_AWLEN[i*8 +: 8];
                s_AWSIZE    = m_AWSIZE[i*3 +: 3];
                s_AWBURST   = m_AWBURST[i*2 +: 2];
                s_AWLOCK    = m_AWLOCK[i];
                s_AWCACHE   = m_AWCACHE[i*4 +: 4];
                s_AWPROT    = m_AWPROT[i*3 +: 3];
                s_AWQOS     = m_AWQOS[i*4 +: 4];
                s_AWREGION  = m_AWREGION[i*4 +: 4];
                s_AWUSER    = m_AWUSER[i*USER_WIDTH +: USER_WIDTH];
                s_WDATA     = m_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
                s_WSTRB     = m_WSTRB[i*STRB_WIDTH +: STRB_WIDTH];
                s_WUSER     = m_WUSER[i*USER_WIDTH +: USER_WIDTH];
                m_wlast_sel = m_WLAST[i];
            end
        end
    end

    // Handshakes are qualified by state; non-owners always see READY/BVALID low,
    // which also holds off any W a master presents before its AW is through.
    assign s_AWVALID = (state_q == StAddr) && |(m_AWVALID & grant_q);
    assign m_AWREADY = ((state_q == StAddr) && s_AWREADY) ? grant_q : '0;

    assign last_beat = (beat_cnt_q == 8'd0);
    assign s_WVALID  = (state_q == StData) && |(m_WVALID & grant_q);
    assign s_WLAST   = (state_q == StData) && last_beat;
    assign m_WREADY  = ((state_q == StData) && s_WREADY) ? grant_q : '0;

    assign m_BID     = s_BID;
    assign m_BRESP   = s_BRESP;
    assign m_BVALID  = ((state_q == StResp) && s_BVALID) ? grant_q : '0;
    assign s_BREADY  = (state_q == StResp) && |(m_BREADY & grant_q);

    assign aw_hs = s_AWVALID && s_AWREADY;
    assign w_hs  = s_WVALID && s_WREADY;
    assign b_hs  = s_BVALID && s_BREADY;

    assign grant     = grant_q;
    assign busy      = (state_q != StIdle);
    assign wlast_err = wlast_err_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        g_d         = g_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        wlast_err_d = w_hs && (m_wlast_sel != last_beat);

        case (state_q)
            StIdle: begin
                if (arb_found) begin
                    g_d     = arb_idx;
                    grant_d = OneHot0 << arb_idx;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                // A master that drops AWVALID keeps the grant until it handshakes.
                if (aw_hs) begin
                    beat_cnt_d = s_AWLEN;
                    state_d    = StData;
                end
            end
            StData: begin
                if (w_hs) begin
                    if (last_beat) begin
                        state_d = StResp;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                end
            end
            StResp: begin
                if (b_hs) begin
                    rr_ptr_d = (g_q == LastIdx) ? '0 : g_q + IDX_WIDTH'(1);
                    grant_d  = '0;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers; reset abandons any transaction in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            g_q         <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            g_q         <= g_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            wlast_err_q <= wlast_err_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_mux_rr.sv
// ---------------------------------------------------------------------------------------------
// tb_axi_wr_mux_rr
//
// Directed bench for axi_wr_mux_rr with 4 masters. A table of single-master transactions
// (owner, AWLEN, bad-WLAST beat, B delay, W backpressure, expected grant and error pulses)
// is replayed in a loop; free-running multi-master sequences cover round-robin order and
// pointer wrap, and a hand sequence covers reset in the middle of a data phase.
// ---------------------------------------------------------------------------------------------
module tb_axi_wr_mux_rr;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int UW = 1;
    localparam int SW = DW / 8;

    logic ACLK = 1'b0;
    logic ARESET;

    logic [N*IW-1:0] m_AWID;
    logic [N*AW-1:0] m_AWADDR;
    logic [N*8-1:0]  m_AWLEN;
    logic [N*3-1:0]  m_AWSIZE;
    logic [N*2-1:0]  m_AWBURST;
    logic [N-1:0]    m_AWLOCK;
    logic [N*4-1:0]  m_AWCACHE;
    logic [N*3-1:0]  m_AWPROT;
    logic [N*4-1:0]  m_AWQOS;
    logic [N*4-1:0]  m_AWREGION;
    logic [N*UW-1:0] m_AWUSER;
    logic [N-1:0]    m_AWVALID, m_AWREADY;
    logic [N*DW-1:0] m_WDATA;
    logic [N*SW-1:0] m_WSTRB;
    logic [N-1:0]    m_WLAST;
    logic [N*UW-1:0] m_WUSER;
    logic [N-1:0]    m_WVALID, m_WREADY;
    logic [IW-1:0]   m_BID;
    logic [1:0]      m_BRESP;
    logic [N-1:0]    m_BVALID, m_BREADY;

    logic [IW-1:0]   s_AWID;
    logic [AW-1:0]   s_AWADDR;
    logic [7:0]      s_AWLEN;
    logic [2:0]      s_AWSIZE;
    logic [1:0]      s_AWBURST;
    logic            s_AWLOCK;
    logic [3:0]      s_AWCACHE;
    logic [2:0]      s_AWPROT;
    logic [3:0]      s_AWQOS;
    logic [3:0]      s_AWREGION;
    logic [UW-1:0]   s_AWUSER;
    logic            s_AWVALID, s_AWREADY;
    logic [DW-1:0]   s_WDATA;
    logic [SW-1:0]   s_WSTRB;
    logic            s_WLAST;
    logic [UW-1:0]   s_WUSER;
    logic            s_WVALID, s_WREADY;
    logic [IW-1:0]   s_BID;
    logic [1:0]      s_BRESP;
    logic            s_BVALID, s_BREADY;

    logic [N-1:0]    grant;
    logic            busy;
    logic            wlast_err;

    always #5 ACLK = ~ACLK;

    axi_wr_mux_rr #(
        .NUM_MASTERS(N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .USER_WIDTH (UW)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .m_AWID    (m_AWID),
        .m_AWADDR  (m_AWADDR),
        .m_AWLEN   (m_AWLEN),
        .m_AWSIZE  (m_AWSIZE),
        .m_AWBURST (m_AWBURST),
        .m_AWLOCK  (m_AWLOCK),
        .m_AWCACHE (m_AWCACHE),
        .m_AWPROT  (m_AWPROT),
        .m_AWQOS   (m_AWQOS),
        .m_AWREGION(m_AWREGION),
        .m_AWUSER  (m_AWUSER),
        .m_AWVALID (m_AWVALID),
        .m_AWREADY (m_AWREADY),
        .m_WDATA   (m_WDATA),
        .m_WSTRB   (m_WSTRB),
        .m_WLAST   (m_WLAST),
        .m_WUSER   (m_WUSER),
        .m_WVALID  (m_WVALID),
        .m_WREADY  (m_WREADY),
        .m_BID     (m_BID),
        .m_BRESP   (m_BRESP),
        .m_BVALID  (m_BVALID),
        .m_BREADY  (m_BREADY),
        .s_AWID    (s_AWID),
        .s_AWADDR  (s_AWADDR),
        .s_AWLEN   (s_AWLEN),
        .s_AWSIZE  (s_AWSIZE),
        .s_AWBURST (s_AWBURST),
        .s_AWLOCK  (s_AWLOCK),
        .s_AWCACHE (s_AWCACHE),
        .s_AWPROT  (s_AWPROT),
        .s_AWQOS   (s_AWQOS),
        .s_AWREGION(s_AWREGION),
        .s_AWUSER  (s_AWUSER),
        .s_AWVALID (s_AWVALID),
        .s_AWREADY (s_AWREADY),
        .s_WDATA   (s_WDATA),
        .s_WSTRB   (s_WSTRB),
        .s_WLAST   (s_WLAST),
        .s_WUSER   (s_WUSER),
        .s_WVALID  (s_WVALID),
        .s_WREADY  (s_WREADY),
        .s_BID     (s_BID),
        .s_BRESP   (s_BRESP),
        .s_BVALID  (s_BVALID),
        .s_BREADY  (s_BREADY),
        .grant     (grant),
        .busy      (busy),
        .wlast_err (wlast_err)
    );

    typedef struct {
        int         m;
        int         len;
        int         bad;        // beat index whose WLAST is inverted, -1 for none
        int         bdelay;     // cycles before s_BVALID rises
        bit         toggle;     // s_WREADY pattern 1,0,1,0...
        logic [3:0] exp_grant;
        int         exp_err;
    } vec_t;

    vec_t vecs [6];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        m_AWID = '0;  m_AWADDR = '0;  m_AWLEN = '0;  m_AWSIZE = '0;  m_AWBURST = '0;
        m_AWLOCK = '0; m_AWCACHE = '0; m_AWPROT = '0; m_AWQOS = '0;  m_AWREGION = '0;
        m_AWUSER = '0; m_AWVALID = '0;
        m_WDATA = '0; m_WSTRB = '0; m_WLAST = '0; m_WUSER = '0; m_WVALID = '0;
        m_BREADY = '0;
        s_AWREADY = 1'b1; s_WREADY = 1'b1;
        s_BID = '0; s_BRESP = '0; s_BVALID = 1'b0;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_grant"}, 64'(grant), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_err"}, 64'(wlast_err), 64'(0));
        check({tag, "_readies"}, 64'({m_AWREADY, m_WREADY, m_BVALID}), 64'(0));
        check({tag, "_svalids"}, 64'({s_AWVALID, s_WVALID, s_BREADY, s_WLAST}), 64'(0));
        check({tag, "_sawaddr"}, 64'(s_AWADDR), 64'(0));
        check({tag, "_swdata"}, s_WDATA, 64'(0));
    endtask

    task automatic set_aw(input int m, input int len);
        m_AWID[m*IW +: IW]   = IW'(m + 1);
        m_AWADDR[m*AW +: AW] = 32'(32'h1000_0000 + m * 256 + len);
        m_AWLEN[m*8 +: 8]    = 8'(len);
        m_AWSIZE[m*3 +: 3]   = 3'd3;
        m_AWBURST[m*2 +: 2]  = 2'b01;
    endtask

    function automatic logic [63:0] wdata_of(input int m, input int beat);
        return {32'hA5A5_0000 | 32'(m), 32'(beat)};
    endfunction

    // One complete transaction from master m; extra masters may request alongside
    // during arbitration only.
    task automatic do_txn(input int m, input int len, input int bad, input int bdelay,
                          input bit toggle, input logic [3:0] exp_grant, input int exp_err,
                          input logic [3:0] extra);
        int beat;
        int cyc;
        int errs;
        set_aw(m, len);
        m_AWVALID = 4'(1 << m) | extra;
        m_WVALID[m] = 1'b1;
        m_WDATA[m*DW +: DW] = wdata_of(m, 0);
        #1;
        check("arb_grant_idle", 64'(grant), 64'(0));
        check("w_before_aw", 64'(m_WREADY), 64'(0));
        step();
        #1;
        check("grant", 64'(grant), 64'(exp_grant));
        check("busy_addr", 64'(busy), 64'(1));
        check("s_awvalid", 64'(s_AWVALID), 64'(1));
        check("s_awaddr", 64'(s_AWADDR), 64'(32'h1000_0000 + m * 256 + len));
        check("s_awlen", 64'(s_AWLEN), 64'(len));
        check("m_awready", 64'(m_AWREADY), 64'(exp_grant));
        check("w_held_in_addr", 64'(m_WREADY), 64'(0));
        m_AWVALID = 4'(1 << m);
        step();
        m_AWVALID = '0;
        beat = 0;
        cyc  = 0;
        errs = 0;
        while (beat <= len && cyc < 600) begin
            m_WDATA[m*DW +: DW] = wdata_of(m, beat);
            m_WSTRB[m*SW +: SW] = '1;
            m_WLAST[m] = (beat == len) ^ (beat == bad);
            s_WREADY = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (wlast_err) errs++;
            check("grant_hold_w", 64'(grant), 64'(exp_grant));
            if (s_WVALID && s_WREADY) begin
                check("s_wdata", s_WDATA, wdata_of(m, beat));
                check("s_wlast", 64'(s_WLAST), 64'(beat == len));
                check("m_wready", 64'(m_WREADY), 64'(exp_grant));
                beat++;
            end
            step();
            cyc++;
        end
        check("w_beats", 64'(beat), 64'(len + 1));
        m_WVALID[m] = 1'b0;
        m_WLAST[m]  = 1'b0;
        s_WREADY    = 1'b1;
        for (int d = 0; d < bdelay; d++) begin
            #1;
            if (wlast_err) errs++;
            check("grant_hold_b", 64'(grant), 64'(exp_grant));
            check("bvalid_wait", 64'(m_BVALID), 64'(0));
            check("wready_resp", 64'(m_WREADY), 64'(0));
            step();
        end
        s_BVALID = 1'b1;
        s_BID    = IW'(m + 1);
        s_BRESP  = 2'(m);
        m_BREADY = 4'(1 << m);
        #1;
        if (wlast_err) errs++;
        check("m_bvalid", 64'(m_BVALID), 64'(exp_grant));
        check("s_bready", 64'(s_BREADY), 64'(1));
        check("m_bid", 64'(m_BID), 64'(m + 1));
        check("m_bresp", 64'(m_BRESP), 64'(m % 4));
        step();
        s_BVALID = 1'b0;
        m_BREADY = '0;
        #1;
        check("grant_released", 64'(grant), 64'(0));
        check("busy_done", 64'(busy), 64'(0));
        check("wlast_err_count", 64'(errs), 64'(exp_err));
        step();
    endtask

    // All masters in mask request continuously with AWLEN=0; checks the first n grants
    // against exp_order (nibble k = k-th expected one-hot grant). Ends with a reset.
    task automatic free_run(input logic [3:0] mask, input int n, input logic [19:0] exp_order);
        int got;
        int cyc;
        int last_start;
        int errs;
        logic [3:0] prev;
        logic [3:0] e;
        int id;
        for (int m = 0; m < N; m++) begin
            if (mask[m]) begin
                set_aw(m, 0);
                m_WDATA[m*DW +: DW] = wdata_of(m, 0);
                m_WSTRB[m*SW +: SW] = '1;
            end
        end
        m_AWVALID = mask;
        m_WVALID  = mask;
        m_WLAST   = mask;
        m_BREADY  = mask;
        s_BVALID  = 1'b1;
        got = 0;
        cyc = 0;
        last_start = 0;
        errs = 0;
        prev = '0;
        while (got < n && cyc < 100) begin
            #1;
            if (wlast_err) errs++;
            if (grant != 4'd0 && prev == 4'd0) begin
                e  = exp_order[got*4 +: 4];
                id = 0;
                for (int j = 0; j < N; j++) if (e[j]) id = j + 1;
                check("rr_order", 64'(grant), 64'(e));
                check("rr_awid", 64'(s_AWID), 64'(id));
                check("rr_awvalid", 64'(s_AWVALID), 64'(1));
                if (got > 0) check("rr_period", 64'(cyc - last_start), 64'(4));
                last_start = cyc;
                got++;
            end
            prev = grant;
            step();
            cyc++;
        end
        check("rr_count", 64'(got), 64'(n));
        check("rr_no_err", 64'(errs), 64'(0));
        clear_inputs();
        do_reset();
    endtask

    initial begin
        vecs[0] = '{2,   3, -1, 0, 1'b0, 4'b0100, 0};  // plain 4-beat burst
        vecs[1] = '{0,   1,  0, 0, 1'b0, 4'b0001, 1};  // early WLAST on beat 1
        vecs[2] = '{1,   3, -1, 5, 1'b1, 4'b0010, 0};  // W backpressure, late B
        vecs[3] = '{3,   0,  0, 2, 1'b0, 4'b1000, 1};  // single beat, WLAST missing
        vecs[4] = '{1,  15,  7, 1, 1'b1, 4'b0010, 1};  // mid-burst WLAST glitch
        vecs[5] = '{0, 255, -1, 0, 1'b0, 4'b0001, 0};  // longest burst

        ARESET = 1'b1;
        clear_inputs();
        step();
        step();
        ARESET = 1'b0;
        #1;
        check_quiet("reset");
        step();

        for (int v = 0; v < 6; v++) begin
            do_txn(vecs[v].m, vecs[v].len, vecs[v].bad, vecs[v].bdelay, vecs[v].toggle,
                   vecs[v].exp_grant, vecs[v].exp_err, 4'b0000);
        end

        // Fairness from a fresh pointer: 0,1,2,3,0
        do_reset();
        free_run(4'b1111, 5, 20'h18421);

        // Pointer wrap: m2 leaves the pointer at 3, then m3 and m0 alternate: 3,0,3
        do_txn(2, 0, -1, 0, 1'b0, 4'b0100, 0, 4'b0000);
        free_run(4'b1001, 3, 20'h00818);

        // Reset mid-DATA: leave the pointer at 3, start a 4-beat burst on m3, reset after beat 1
        do_txn(2, 0, -1, 0, 1'b0, 4'b0100, 0, 4'b0000);
        set_aw(3, 3);
        m_AWVALID = 4'b1000;
        m_WVALID  = 4'b1000;
        m_WDATA[3*DW +: DW] = wdata_of(3, 0);
        step();
        #1;
        check("mid_grant", 64'(grant), 64'(4'b1000));
        step();
        m_AWVALID = '0;
        #1;
        check("mid_beat1", 64'(s_WVALID && s_WREADY), 64'(1));
        step();
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        #1;
        check_quiet("mid_reset");
        m_WVALID = '0;
        // m1 and m3 both request; a cleared pointer must pick m1
        do_txn(1, 0, -1, 0, 1'b0, 4'b0010, 0, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/axi_wr_mux_rr.md
Name: axi_wr_mux_rr

Overview:
- Parametrised N-master to 1-slave AXI4 write-channel multiplexer with a built-in round-robin arbiter.
- Supersedes the fixed 4-master, externally-granted write mux.
- Owns the grant for a whole transaction: AW, all W beats, then B. The grant is released only after the B handshake.
- Counts W beats against AWLEN, regenerates WLAST toward the slave, and flags masters whose WLAST disagrees with AWLEN.
- Sits between the master-side ports and each slave's write-address decoder in the interconnect.

Parameters:
- NUM_MASTERS, 4, number of master ports (2..16).
- DATA_WIDTH, 64, W data width.
- ADDR_WIDTH, 32, AW address width.
- ID_WIDTH, 4, AXI ID width.
- USER_WIDTH, 1, AWUSER/WUSER width.
- STRB_WIDTH, DATA_WIDTH/8, WSTRB width.
- IDX_WIDTH, $clog2(NUM_MASTERS), width of the grant index.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- m_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT/AWQOS/AWREGION/AWUSER  in  NUM_MASTERS x field width  packed per-master AW fields; master i occupies slice i.
- m_AWVALID  in  NUM_MASTERS  per-master AW valid.
- m_AWREADY  out  NUM_MASTERS  per-master AW ready.
- m_WDATA/WSTRB/WLAST/WUSER  in  NUM_MASTERS x field width  packed per-master W fields.
- m_WVALID  in  NUM_MASTERS  per-master W valid.
- m_WREADY  out  NUM_MASTERS  per-master W ready.
- m_BID  out  ID_WIDTH  broadcast B ID.
- m_BRESP  out  2  broadcast B response.
- m_BVALID  out  NUM_MASTERS  per-master B valid.
- m_BREADY  in  NUM_MASTERS  per-master B ready.
- s_AW* (same 11 fields)  out  field width  slave-side AW fields.
- s_AWVALID  out  1.
- s_AWREADY  in  1.
- s_WDATA/WSTRB/WUSER  out  field width.
- s_WLAST  out  1  regenerated last flag.
- s_WVALID  out  1.
- s_WREADY  in  1.
- s_BID  in  ID_WIDTH.
- s_BRESP  in  2.
- s_BVALID  in  1.
- s_BREADY  out  1.
- grant  out  NUM_MASTERS  one-hot current owner; zero when idle.
- busy  out  1  high in ADDR/DATA/RESP.
- wlast_err  out  1  one-cycle pulse on WLAST mismatch.

Behaviour:
- Reset values: FSM=IDLE, rr_ptr=0, beat_cnt=0, grant=0, busy=0, wlast_err=0.
  - All of m_AWREADY, m_WREADY, m_BVALID, s_AWVALID, s_WVALID, s_BREADY are 0.
  - All s_* data fields are 0.
- Reset mid-transaction: the FSM returns to IDLE on the next edge and the transaction is abandoned; there is no drain.
- Outputs are combinational from registered state plus the granted master's inputs. Non-granted masters see READY=0 and BVALID=0.
- s_* fields are zero whenever grant=0.
- m_BID and m_BRESP broadcast s_BID and s_BRESP.
- IDLE:
  - If any m_AWVALID is high, select the first requester scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_MASTERS.
  - Register its index g and one-hot grant, then go to ADDR.
  - Arbitration latency is 1 cycle from AWVALID to grant.
  - No request: stay in IDLE.
- ADDR:
  - s_AW* = master g's fields; s_AWVALID = m_AWVALID[g]; m_AWREADY[g] = s_AWREADY.
  - On handshake: beat_cnt <= AWLEN, go to DATA.
- DATA:
  - s_W* = master g's fields; s_WVALID = m_WVALID[g]; m_WREADY[g] = s_WREADY.
  - s_WLAST = (beat_cnt==0), independent of master WLAST.
  - On each handshake: if beat_cnt!=0, decrement. If beat_cnt==0, go to RESP.
  - wlast_err pulses for 1 cycle on any handshake where m_WLAST[g] != (beat_cnt==0).
- W before AW: a master's WVALID is ignored (WREADY=0) until that master is granted and in DATA.
- RESP:
  - m_BVALID[g] = s_BVALID; s_BREADY = m_BREADY[g].
  - On handshake: rr_ptr <= (g+1) mod NUM_MASTERS, grant <= 0, go to IDLE.
- Back-to-back: minimum per-transaction overhead is 1 idle (arbitration) cycle after the B handshake.
- A master that drops AWVALID after being granted keeps the grant in ADDR until it handshakes; AXI forbids dropping AWVALID.
- AWLEN=255 gives 256 beats; beat_cnt is 8 bits and does not wrap.

Test Plan:
- Single master: m2 issues AWLEN=3 with s_*READY=1. Grant=4'b0100 one cycle after AWVALID; exactly 4 W handshakes; s_WLAST only on beat 4; B routed only to m_BVALID[2]; busy falls after B.
- Fairness: all 4 masters hold AWVALID continuously, AWLEN=0. Grant order is 0,1,2,3,0; each master's AW is forwarded once per round.
- Pointer wrap: after m3 completes with only m0 and m3 requesting, the next grant is m0, then m3.
- WLAST mismatch: AWLEN=1 and master asserts WLAST on beat 1. wlast_err pulses exactly once; s_WLAST is asserted on beat 2; transaction completes normally.
- Backpressure: s_WREADY toggles 1,0,1,0 and s_BVALID is delayed 5 cycles. No beat is lost or duplicated, and grant is held throughout.
- Reset mid-DATA: ARESET asserted for 1 cycle after beat 1 of 4. Next cycle: grant=0, all valids/readies 0, FSM in IDLE, rr_ptr=0. A new request from m1 is granted cleanly.
